fetch_unit: RTL

- Instruction-fetch stage directly upstream of decode/execute. Owns the architectural fetch PC and issues word requests to instruction memory over a valid/ready port.
- Buffers returned instructions with their PCs in a small FIFO toward decode.
- Accepts redirects carrying the resolved control-flow target from the branch/jump resolution logic. On a redirect it flushes buffered work and discards stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_sync_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional misalignment trap is controlled by FETCH_MISALIGN_CHECK_EN.
package fetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_INC    = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // One instruction-buffer entry; pc sits in the upper half.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of redirect, instruction-memory and decode-side signals of the fetch stage.
// master = fetch stage, slave = surrounding pipeline and memory.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [XLEN-1:0]    id_pc;
    logic               fetch_misalign;

    modport master (
        input  redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, id_ready,
        output imem_req_valid, imem_req_addr, id_valid, id_instr,
               id_pc, fetch_misalign
    );

    modport slave (
        output redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, id_ready,
        input  imem_req_valid, imem_req_addr, id_valid, id_instr,
               id_pc, fetch_misalign
    );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; DEPTH must be a power of two.
// Flush wins over any same-cycle push or pop.
module fetch_unit_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !flush && (count_reg != CW'(DEPTH));
    assign pop_ok  = pop  && !flush && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues imem requests and buffers returns.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets into HALT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = $bits(fetch_entry_t);

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [1:0] ST_HALT = HALT;
`endif

    logic [1:0]      state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   live;
    logic [CW:0]     in_flight;
    logic            req_fire;
    logic            rsp_fire;
    logic            dropping;
    logic            id_fire;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [EW-1:0]   head_bits;
    fetch_entry_t    head;

    // Live requests plus buffered entries must fit the buffer, so a response never finds it full.
    assign live      = outstanding - drop_cnt_reg;
    assign in_flight = {1'b0, live} + {1'b0, fifo_cnt};

    assign bus.imem_req_valid = (state_reg == ST_RUN) &&
                                (outstanding < CW'(FIFO_DEPTH)) &&
                                (in_flight < (CW+1)'(FIFO_DEPTH));
    assign bus.imem_req_addr  = fetch_pc_reg;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid;
    assign dropping = (drop_cnt_reg != '0);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_reg, misalign_next;
    logic target_misaligned;

    assign target_pc          = bus.redirect_target;
    assign target_misaligned  = |bus.redirect_target[1:0];
    assign bus.fetch_misalign = misalign_reg;
`else
    logic unused_target_bits;

    assign target_pc          = {bus.redirect_target[XLEN-1:2], 2'b00};
    assign unused_target_bits = ^bus.redirect_target[1:0];
    assign bus.fetch_misalign = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_BOOT) begin
            state_next = ST_RUN;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_next = misalign_reg;
        if (bus.redirect_valid) begin
            state_next    = target_misaligned ? ST_HALT : ST_RUN;
            misalign_next = target_misaligned;
        end
`endif
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        drop_cnt_next = drop_cnt_reg;
        if (bus.redirect_valid) begin
            fetch_pc_next = target_pc;
            // Everything still in flight, including a request firing right now, is stale.
            drop_cnt_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
        end else begin
            if (req_fire)             fetch_pc_next = fetch_pc_reg + PC_INC;
            if (rsp_fire && dropping) drop_cnt_next = drop_cnt_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            fetch_pc_reg <= RESET_PC;
            drop_cnt_reg <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            drop_cnt_reg <= drop_cnt_next;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    // PC queue: its occupancy is the outstanding-request count; it is never flushed
    // because stale responses still have to pop their entries.
    fetch_unit_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (rsp_fire),
        .pop_data  (rsp_pc),
        .count     (outstanding)
    );

    fetch_unit_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (rsp_fire && !dropping),
        .push_data ({rsp_pc, bus.imem_rsp_data}),
        .pop       (id_fire),
        .pop_data  (head_bits),
        .count     (fifo_cnt)
    );

    assign head         = fetch_entry_t'(head_bits);
    assign bus.id_valid = (fifo_cnt != '0) && !bus.redirect_valid;
    assign id_fire      = bus.id_valid && bus.id_ready;
    assign bus.id_pc    = head.pc;
    assign bus.id_instr = bus.id_valid ? head.instr : NOP_INSTR;

endmodule
